accum_seq: RTL and testbench
============================

ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have parameter N_MAX, default 16, the maximum operands per batch (legal range 1..31).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a batch; sampled only in IDLE.
REQ-005 SHALL have port count  input  5  number of operands in the batch, sampled with start.
REQ-006 SHALL have port in_valid  input  1  operand beat valid.
REQ-007 SHALL have port in_data  input  21  unsigned operand.
REQ-008 SHALL have port in_ready  output  1  the block accepts an operand this cycle.
REQ-009 SHALL have port out_valid  output  1  batch result valid.
REQ-010 SHALL have port out_sum  output  21  accumulated sum.
REQ-011 SHALL have port out_ovf  output  5  count of carry-outs during the batch.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-015 SHALL, in IDLE with start=1, clear the accumulator and overflow counter, load remaining=count, and go to ACCUM.
REQ-016 SHALL clamp count>N_MAX to N_MAX at load time.
REQ-017 SHALL, on start with count=0, go directly to DONE with out_sum=0 and out_ovf=0.
REQ-018 SHALL ignore start in ACCUM and DONE.
REQ-019 SHALL drive in_ready=1 only in ACCUM; a beat transfers when in_valid and in_ready are both 1 in the same cycle.
REQ-020 SHALL, on each transfer, form the 21-bit sum acc+in_data with carry-in 0, register the 21-bit sum, and increment out_ovf when the carry-out is 1.
REQ-021 SHALL saturate out_ovf at 31.
REQ-022 SHALL decrement remaining on each transfer.
REQ-023 SHALL move from ACCUM to DONE in the cycle the transfer with remaining=1 occurs.
REQ-024 SHALL assert out_valid the cycle after the last transfer, so latency from the last beat to result is 1 cycle.
REQ-025 SHALL hold out_valid, out_sum and out_ovf stable in DONE until out_ready=1.
REQ-026 SHALL return to IDLE the cycle after out_valid and out_ready are both 1.
REQ-027 SHALL make in_valid gaps in ACCUM (in_valid=0) stall the batch without changing state.
REQ-028 SHALL present out_sum and out_ovf as the live accumulator values outside DONE; consumers qualify them with out_valid only.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state=IDLE, acc=0, out_ovf=0, remaining=0, out_valid=0, in_ready=0, busy=0.
REQ-030 SHALL give rst priority over start, in_valid and out_ready in the same cycle.
REQ-031 SHALL, on reset mid-batch or in DONE, discard the partial result with no out_valid pulse.

Configuration
REQ-032 SHALL, when SATURATE_EN is defined, clamp the accumulator to 21'h1FFFFF on any carry-out and keep it there for the rest of the batch; out_ovf still counts carries.
REQ-033 SHALL, when SATURATE_EN is undefined, wrap the accumulator modulo 2^21.

Verification
REQ-034 SHALL be tested with: start, count=3, beats 5, 10, 20 with no gaps -> out_valid 1 cycle after the third beat, out_sum=35, out_ovf=0.
REQ-035 SHALL be tested with: count=2, beats 21'h1FFFFF then 2 -> out_ovf=1; out_sum=1 without SATURATE_EN, 21'h1FFFFF with it.
REQ-036 SHALL be tested with: count=0 -> out_valid the cycle after start, out_sum=0, in_ready never 1.
REQ-037 SHALL be tested with: count=31, N_MAX=16, 16 beats of 1 -> DONE after the 16th beat, out_sum=16.
REQ-038 SHALL be tested with: out_ready=0 for 5 cycles in DONE, with start pulsed -> outputs stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-039 SHALL be tested with: rst after 2 of 4 beats -> next cycle IDLE, busy=0, out_valid=0; a new batch of count=1, beat 7 -> out_sum=7.

Source files
------------

// File: rtl/accum_seq.sv
// Batch accumulator: takes a counted batch of 21-bit operands, sums them and counts carry-outs.
// Optional build macro SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module accum_seq #(
  parameter int N_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  count,
  input  logic        in_valid,
  input  logic [20:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [20:0] out_sum,
  output logic [4:0]  out_ovf,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] N_MAX_W = 5'(N_MAX);

  state_t      state_q;
  logic [20:0] acc_q;
  logic [20:0] acc_d;
  logic [4:0]  ovf_q;
  logic [4:0]  ovf_d;
  logic [4:0]  rem_q;
  logic [4:0]  load_cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        xfer;
  logic [21:0] sum_full;
  logic        carry;

  always_comb begin
    load_cnt = (count > N_MAX_W) ? N_MAX_W : count;
    xfer     = in_valid && in_ready_q;
    sum_full = {1'b0, acc_q} + {1'b0, in_data};
    carry    = sum_full[21];
`ifdef SATURATE_EN
    // Once pinned at all-ones any further non-zero operand carries again, so it stays pinned.
    acc_d    = carry ? 21'h1FFFFF : sum_full[20:0];
`else
    acc_d    = sum_full[20:0];
`endif
    ovf_d    = (carry && (ovf_q != 5'd31)) ? ovf_q + 5'd1 : ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= '0;
            busy_q <= 1'b1;
            if (load_cnt == 5'd0) begin
              state_q     <= DONE;
              rem_q       <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACCUM;
              rem_q      <= load_cnt;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Sum and carry count are the live accumulator; only out_valid qualifies them.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq: vector table through a result scoreboard plus corner sequences.
module tb_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  count;
  logic        in_valid;
  logic [20:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [20:0] out_sum;
  logic [4:0]  out_ovf;
  logic        out_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  accum_seq #(.N_MAX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [20:0] s;
    logic [4:0]  o;
  } exp_t;

  typedef struct {
    logic [4:0]       count;
    int               nb;
    logic [3:0][20:0] beats;
    logic [20:0]      es;
    logic [4:0]       eo;
    logic             gaps;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, {11'd0, out_sum}, {11'd0, e.s});
      check({tag, "_ovf"}, {27'd0, out_ovf}, {27'd0, e.o});
      $display("txn %s: sum=%0h ovf=%0d (exp %0h/%0d)", tag, out_sum, out_ovf, e.s, e.o);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Drives one batch and leaves the block in DONE with the result checked.
  task automatic run_batch(input vec_t v, input string tag);
    start = 1'b1;
    count = v.count;
    sb.push_back('{s: v.es, o: v.eo});
    step();
    start = 1'b0;
    for (int i = 0; i < v.nb; i++) begin
      if (v.gaps) begin
        in_valid = 1'b0;
        step();
        check({tag, "_gap_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_gap_valid"}, {31'd0, out_valid}, 32'd0);
      end
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = v.beats[i];
      step();
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
    if (!out_valid) wait_valid();
    check({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    pop_compare(tag);
  endtask

  initial begin
    vecs[0] = '{count: 5'd3, nb: 3, beats: {21'd0, 21'd20, 21'd10, 21'd5},
                es: 21'd35, eo: 5'd0, gaps: 1'b0};
`ifdef SATURATE_EN
    vecs[1] = '{count: 5'd2, nb: 2, beats: {21'd0, 21'd0, 21'd2, 21'h1FFFFF},
                es: 21'h1FFFFF, eo: 5'd1, gaps: 1'b0};
    vecs[3] = '{count: 5'd4, nb: 4, beats: {21'd3, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF},
                es: 21'h1FFFFF, eo: 5'd3, gaps: 1'b1};
    vecs[4] = '{count: 5'd2, nb: 2, beats: {21'd0, 21'd0, 21'h100000, 21'h100000},
                es: 21'h1FFFFF, eo: 5'd1, gaps: 1'b0};
`else
    vecs[1] = '{count: 5'd2, nb: 2, beats: {21'd0, 21'd0, 21'd2, 21'h1FFFFF},
                es: 21'd1, eo: 5'd1, gaps: 1'b0};
    vecs[3] = '{count: 5'd4, nb: 4, beats: {21'd3, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF},
                es: 21'd0, eo: 5'd3, gaps: 1'b1};
    vecs[4] = '{count: 5'd2, nb: 2, beats: {21'd0, 21'd0, 21'h100000, 21'h100000},
                es: 21'd0, eo: 5'd1, gaps: 1'b0};
`endif
    vecs[2] = '{count: 5'd1, nb: 1, beats: {21'd0, 21'd0, 21'd0, 21'd7},
                es: 21'd7, eo: 5'd0, gaps: 1'b1};

    rst = 1'b1; start = 1'b1; count = 5'd3; in_valid = 1'b1; in_data = 21'd9; out_ready = 1'b0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {11'd0, out_sum}, 32'd0);
    check("rst_ovf", {27'd0, out_ovf}, 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_batch(vecs[i], $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // count=0 goes straight to DONE
    start = 1'b1; count = 5'd0;
    step();
    start = 1'b0;
    check("zero_valid", {31'd0, out_valid}, 32'd1);
    check("zero_in_ready", {31'd0, in_ready}, 32'd0);
    check("zero_sum", {11'd0, out_sum}, 32'd0);
    check("zero_ovf", {27'd0, out_ovf}, 32'd0);
    $display("txn zero: sum=%0h ovf=%0d", out_sum, out_ovf);
    release_result("zero");

    // count above N_MAX is clamped to 16 beats
    start = 1'b1; count = 5'd31;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clamp_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = 21'd1;
      step();
    end
    in_valid = 1'b0;
    check("clamp_valid", {31'd0, out_valid}, 32'd1);
    check("clamp_in_ready_off", {31'd0, in_ready}, 32'd0);
    check("clamp_sum", {11'd0, out_sum}, 32'd16);
    $display("txn clamp: sum=%0h ovf=%0d", out_sum, out_ovf);
    release_result("clamp");

    // hold in DONE with start pulsed
    run_batch(vecs[0], "hold");
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; count = 5'd3;
      step();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {11'd0, out_sum}, 32'd35);
      check("hold_ovf", {27'd0, out_ovf}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0;
    release_result("hold");
    check("hold_after_in_ready", {31'd0, in_ready}, 32'd0);

    // reset mid-batch, racing a beat and out_ready
    start = 1'b1; count = 5'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 21'd100;
      step();
    end
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    run_batch(vecs[2], "after_rst");
    release_result("after_rst");

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
